cbus_rr_arbiter: RTL and testbench
==================================

Name: cbus_rr_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes NUM_CH cache-bus masters (I$, D$, uncached path, future PTW) onto the single cbus_req_t/cbus_resp_t port toward the AXI bridge.
- Successor to the fixed 2-way I/D mux: generalised channel count, round-robin fairness, burst locking, beat counting, protocol-error detection.
- Sits between the cache layer and the AXI master adapter.

Parameters:
- NUM_CH, 2, number of requesting masters (>=2).
- IDX_W, $clog2(NUM_CH), width of channel index (derived, not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ireqs  in  NUM_CH x cbus_req_t  per-channel requests; index 0 = channel 0.
- iresps  out  NUM_CH x cbus_resp_t  per-channel responses.
- oreq  out  cbus_req_t  request to AXI bridge.
- oresp  in  cbus_resp_t  response from AXI bridge.
- grant_idx  out  IDX_W  currently owning channel (valid when busy=1).
- busy  out  1  a channel owns the bus.
- proto_err  out  1  one-cycle pulse on burst-length mismatch or mid-burst abort.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, ptr=NUM_CH-1, grant_idx=0, busy=0, beat_cnt=0, proto_err=0; oreq and all iresps all-zero.
- States:
  - IDLE: oreq='0, iresps='0. If any ireqs[i].valid, choose the first valid i scanning ptr+1, ptr+2, ... modulo NUM_CH. Register grant_idx=i, beat_cnt=0, go BUSY. Arbitration latency is one cycle: the request appears on oreq the cycle after valid is first seen in IDLE.
  - BUSY: oreq=ireqs[grant_idx] combinationally; iresps[grant_idx]=oresp; every other iresps[j]='0. Requests from other channels are held off; their valid is ignored.
    - On oresp.ready: beat_cnt++.
    - On oresp.ready && oresp.last: ptr<=grant_idx, go IDLE; busy=0 next cycle.
- Burst check: at the last beat, expected beats = oreq.len+1 (mlen_t, 8 bits; beat_cnt is 9 bits so MLEN256 = 256 beats does not wrap). If beat_cnt+1 != len+1, pulse proto_err in the following cycle. The transfer still completes normally.
- Abort: if ireqs[grant_idx].valid drops while BUSY and the cycle is not the last beat, then oreq.valid=0 that cycle, go IDLE, pulse proto_err next cycle, ptr<=grant_idx.
- Back-to-back: no combinational path from oresp to grant. After last, there is at least one IDLE cycle before the next grant, and the bridge sees oreq.valid=0 for that cycle.
- Round-robin wrap: ptr=NUM_CH-1 makes the scan start at 0. With all channels continuously valid, grants cycle 0,1,...,NUM_CH-1,0.
- Simultaneous ready && last && valid-drop: treated as normal completion, no error.
- Reset mid-burst: bus is released immediately; the bridge is responsible for its own AXI state.
- Masters must hold ireqs fields stable while BUSY and granted. Changing addr/len mid-burst is undefined, not detected.

Optional Feature:
- CBUS_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins. ptr is not used; the scan always starts at 0. Channel 0 (intended for D$) can starve higher indices.
  - Undefined: round-robin as above.
- Burst locking, beat counting and proto_err are identical in both modes.

Test Plan:
- Single request: ch1 valid, len=MLEN16, read; bridge returns 16 ready beats, last on beat 16 -> oreq.valid rises 1 cycle after ch1.valid; iresps[1] mirrors 16 beats; iresps[0]=0 throughout; busy falls the cycle after last; proto_err never asserted.
- Fairness, NUM_CH=4, all four valid continuously, MLEN1 each -> grant_idx sequence 0,1,2,3,0,1 with one IDLE cycle between grants. With CBUS_ARB_FIXED_PRIO_EN -> 0,0,0...
- Length mismatch: ch0 len=MLEN8, bridge asserts last on beat 4 -> proto_err pulses exactly one cycle after beat 4; arbiter returns to IDLE; next valid channel is granted normally.
- Abort: ch2 granted with len=MLEN4, drops valid after beat 2 -> oreq.valid=0 that cycle; proto_err pulse next cycle; ptr=2, so a pending ch3 is granted next.
- MLEN256 burst: 256 beats with last on beat 256 -> no proto_err (checks the 9-bit counter).
- Reset mid-burst: resetn low during beat 3 of an MLEN8 burst -> oreq, iresps, busy, grant_idx zero immediately (asynchronous); after release, the first valid channel scanning from 0 is granted.

Source files
------------

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-channel cache-bus arbiter with burst locking, beat counting and protocol-error pulse
// Define CBUS_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
package cbus_pkg;
  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1   = 8'd0;
  localparam mlen_t MLEN4   = 8'd3;
  localparam mlen_t MLEN8   = 8'd7;
  localparam mlen_t MLEN16  = 8'd15;
  localparam mlen_t MLEN256 = 8'd255;
  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [31:0] addr;
    mlen_t       len;
    logic [31:0] wdata;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NUM_CH],
  output cbus_resp_t       iresps [NUM_CH],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             proto_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, base, pick, cand;
  logic [8:0]       beat_q, beat_d;
  logic             err_q, err_d, found, fin, abort;
`ifdef CBUS_ARB_FIXED_PRIO_EN
  assign base = IDX_W'(NUM_CH - 1);
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign base = ptr_q;
  // remember the last owner so the next scan starts just after it
  always_comb ptr_d = (state_q == BUSY && (fin || abort)) ? grant_q : ptr_q;
  // round-robin pointer register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ptr_q <= IDX_W'(NUM_CH - 1);
    else ptr_q <= ptr_d;
`endif
  // pick the first valid channel scanning base+1, base+2, ... modulo NUM_CH
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((int'(base) + k) % NUM_CH);
      if (!found && ireqs[cand].valid) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end
  // next-state, bus muxing, beat counting and burst/abort error detection
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    oreq    = '0;
    iresps  = '{default: '0};
    if (state_q == IDLE) begin
      state_d = found ? BUSY : IDLE;
      grant_d = found ? pick : grant_q;
      beat_d  = '0;
    end else begin
      fin             = oresp.ready && oresp.last;
      abort           = !ireqs[grant_q].valid && !fin;
      oreq            = ireqs[grant_q];
      oreq.valid      = ireqs[grant_q].valid && !abort;
      iresps[grant_q] = oresp;
      beat_d          = oresp.ready ? beat_q + 9'd1 : beat_q;
      state_d         = (fin || abort) ? IDLE : BUSY;
      err_d           = abort || (fin && beat_q != {1'b0, ireqs[grant_q].len});
    end
  end
  // state registers; reset releases the bus immediately
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  assign busy      = state_q == BUSY;
  assign grant_idx = grant_q;
  assign proto_err = err_q;
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: scoreboard bench for the 4-channel cache-bus arbiter
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;
  localparam int N = 4;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic [1:0] grant_idx;
  logic       busy, proto_err;
  int         total = 0, bad = 0;
  logic [31:0] exp_q [$];
  int          gnt_q [$];

  always #5 clk = ~clk;

  cbus_rr_arbiter #(.NUM_CH(N)) dut (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps), .oreq(oreq),
    .oresp(oresp), .grant_idx(grant_idx), .busy(busy), .proto_err(proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input int ch, input bit v, input mlen_t len);
    ireqs[ch] = '{valid: v, wr: 1'b0, addr: 32'h1000 + 32'(ch) * 32'h100, len: len, wdata: 32'(ch)};
  endtask

  task automatic clear_all();
    for (int j = 0; j < N; j++) req(j, 1'b0, MLEN1);
    oresp = '0;
  endtask

  task automatic start(input int ch, input mlen_t len);
    step();
    req(ch, 1'b1, len);
    smp();
    total++;
    if (busy !== 1'b0 || oreq.valid !== 1'b0) begin
      bad++;
      $display("FAIL latency ch%0d: busy=%b oreq.valid=%b want 0 0", ch, busy, oreq.valid);
    end
  endtask

  task automatic do_beats(input int ch, input int n, input int last_at);
    logic [31:0] e;
    for (int b = 1; b <= n; b++) begin
      step();
      oresp = '{ready: 1'b1, last: (b == last_at), rdata: 32'(ch * 1000 + b)};
      exp_q.push_back(32'(ch * 1000 + b));
      smp();
      e = exp_q.pop_front();
      total++;
      if (iresps[ch].rdata !== e || iresps[ch].ready !== 1'b1) begin
        bad++;
        $display("FAIL beat ch%0d b%0d: rdata=%h ready=%b want %h 1", ch, b, iresps[ch].rdata, iresps[ch].ready, e);
      end
      total++;
      if (busy !== 1'b1 || grant_idx !== 2'(ch) || oreq.valid !== 1'b1 || oreq.addr !== 32'h1000 + 32'(ch) * 32'h100) begin
        bad++;
        $display("FAIL owner ch%0d b%0d: busy=%b grant=%0d valid=%b addr=%h", ch, b, busy, grant_idx, oreq.valid, oreq.addr);
      end
      total++;
      if (proto_err !== 1'b0) begin
        bad++;
        $display("FAIL err_in_burst ch%0d b%0d: proto_err=%b want 0", ch, b, proto_err);
      end
      for (int j = 0; j < N; j++)
        if (j != ch) begin
          total++;
          if (iresps[j] !== '0) begin
            bad++;
            $display("FAIL leak ch%0d b%0d: iresps[%0d]=%h want 0", ch, b, j, iresps[j]);
          end
        end
    end
  endtask

  task automatic tail(input int ch, input bit exp_err);
    step();
    req(ch, 1'b0, MLEN1);
    oresp = '0;
    smp();
    total++;
    if (proto_err !== exp_err || busy !== 1'b0 || oreq.valid !== 1'b0) begin
      bad++;
      $display("FAIL tail ch%0d: proto_err=%b busy=%b valid=%b want %b 0 0", ch, proto_err, busy, oreq.valid, exp_err);
    end
    step();
    smp();
    total++;
    if (proto_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse ch%0d: proto_err=%b want 0", ch, proto_err);
    end
  endtask

  task automatic test_reset();
    clear_all();
    resetn = 1'b0;
    req(1, 1'b1, MLEN4);
    step();
    smp();
    total++;
    if (busy !== 1'b0 || grant_idx !== 2'd0 || proto_err !== 1'b0 || oreq !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b grant=%0d err=%b oreq=%h", busy, grant_idx, proto_err, oreq);
    end
    for (int j = 0; j < N; j++) begin
      total++;
      if (iresps[j] !== '0) begin
        bad++;
        $display("FAIL reset_iresp: iresps[%0d]=%h want 0", j, iresps[j]);
      end
    end
    clear_all();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_single();
    start(1, MLEN16);
    do_beats(1, 16, 16);
    tail(1, 1'b0);
  endtask

  task automatic test_fairness();
    int g;
    resetn = 1'b0;
    clear_all();
    step();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) gnt_q.push_back(i % N);
    step();
    for (int j = 0; j < N; j++) req(j, 1'b1, MLEN1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      oresp = '0;
      smp();
      total++;
      if (busy !== 1'b0 || oreq.valid !== 1'b0 || proto_err !== 1'b0) begin
        bad++;
        $display("FAIL idle_gap %0d: busy=%b valid=%b err=%b want 0 0 0", i, busy, oreq.valid, proto_err);
      end
      step();
      oresp = '{ready: 1'b1, last: 1'b1, rdata: 32'(i)};
      smp();
      g = gnt_q.pop_front();
      total++;
      if (busy !== 1'b1 || grant_idx !== 2'(g)) begin
        bad++;
        $display("FAIL rr_order %0d: busy=%b grant=%0d want 1 %0d", i, busy, grant_idx, g);
      end
    end
    step();
    clear_all();
    smp();
    total++;
    if (proto_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_end: err=%b busy=%b want 0 0", proto_err, busy);
    end
  endtask

  task automatic test_len_mismatch();
    start(0, MLEN8);
    do_beats(0, 4, 4);
    tail(0, 1'b1);
    start(3, MLEN1);
    do_beats(3, 1, 1);
    tail(3, 1'b0);
  endtask

  task automatic test_abort();
    start(2, MLEN4);
    do_beats(2, 2, 0);
    step();
    req(2, 1'b0, MLEN4);
    req(0, 1'b1, MLEN1);
    req(3, 1'b1, MLEN1);
    oresp = '0;
    smp();
    total++;
    if (oreq.valid !== 1'b0 || busy !== 1'b1 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL abort_cycle: valid=%b busy=%b err=%b want 0 1 0", oreq.valid, busy, proto_err);
    end
    step();
    smp();
    total++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_err: err=%b busy=%b want 1 0", proto_err, busy);
    end
    do_beats(3, 1, 1);
    step();
    req(3, 1'b0, MLEN1);
    oresp = '0;
    smp();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_gap: busy=%b want 0", busy);
    end
    do_beats(0, 1, 1);
    tail(0, 1'b0);
  endtask

  task automatic test_mlen256();
    start(1, MLEN256);
    do_beats(1, 256, 256);
    tail(1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    start(2, MLEN8);
    do_beats(2, 2, 0);
    step();
    oresp = '{ready: 1'b1, last: 1'b0, rdata: 32'h3};
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || grant_idx !== 2'd0 || oreq !== '0 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: busy=%b grant=%0d oreq=%h err=%b", busy, grant_idx, oreq, proto_err);
    end
    for (int j = 0; j < N; j++) begin
      total++;
      if (iresps[j] !== '0) begin
        bad++;
        $display("FAIL async_reset_iresp: iresps[%0d]=%h want 0", j, iresps[j]);
      end
    end
    clear_all();
    req(1, 1'b1, MLEN1);
    req(3, 1'b1, MLEN1);
    step();
    resetn = 1'b1;
    smp();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%b want 0", busy);
    end
    step();
    smp();
    total++;
    if (busy !== 1'b1 || grant_idx !== 2'd1) begin
      bad++;
      $display("FAIL post_reset_grant: busy=%b grant=%0d want 1 1", busy, grant_idx);
    end
    step();
    clear_all();
  endtask

  initial begin
    clear_all();
    test_reset();
    test_single();
    test_fairness();
    test_len_mismatch();
    test_abort();
    test_mlen256();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
